// File: rtl/tick_gen_1s_if.sv
// Control and status bundle for the 1 s timebase: host drives start/stop/pause,
// the generator returns the tick strobe, run state and elapsed tick count.
interface tick_gen_1s_if #(
    parameter int unsigned SEC_W = 8
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             timeout1s;
    logic             running;
    logic             paused;
    logic [SEC_W-1:0] elapsed;

    modport master (
        output start, stop, pause,
        input  timeout1s, running, paused, elapsed
    );

    modport slave (
        input  start, stop, pause,
        output timeout1s, running, paused, elapsed
    );
endinterface

// File: rtl/tick_gen_1s.sv
// Divides clk into a one-cycle strobe every CLK_HZ/TICK_HZ cycles, with
// start/stop/pause control that freezes sub-tick phase while paused.
module tick_gen_1s #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned SEC_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    tick_gen_1s_if.slave  bus
);
    localparam int unsigned DIV  = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
    localparam int unsigned PW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_gen_1s: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    presc_q;
    logic             tick_q;
    logic [SEC_W-1:0] elapsed_q;

    // Priority on every edge is stop > start > pause; the strobe defaults low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            elapsed_q <= '0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    presc_q <= '0;
                    if (!bus.stop && bus.start) begin
                        state_q   <= RUN;
                        elapsed_q <= '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        presc_q <= '0;
                    end else if (bus.start) begin
                        presc_q   <= '0;
                        elapsed_q <= '0;
                    end else if (bus.pause) begin
                        state_q <= PAUSE;
                    end else if (presc_q == LAST) begin
                        presc_q   <= '0;
                        tick_q    <= 1'b1;
                        elapsed_q <= elapsed_q + SEC_W'(1);
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    // prescaler is left untouched so phase survives the pause
                    if (bus.stop) begin
                        state_q <= IDLE;
                        presc_q <= '0;
                    end else if (bus.start) begin
                        state_q   <= RUN;
                        presc_q   <= '0;
                        elapsed_q <= '0;
                    end else if (bus.pause) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign bus.timeout1s = tick_q;
    assign bus.running   = (state_q == RUN);
    assign bus.paused    = (state_q == PAUSE);
    assign bus.elapsed   = elapsed_q;

endmodule

// File: tb/tb_tick_gen_1s.sv
// Bench for tick_gen_1s at DIV=10: directed scenarios plus a random control
// sequence checked against an edge-counting reference model.
module tb_tick_gen_1s;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Reference model: period progress counted in edges, whole ticks since start.
    bit m_active;
    bit m_frozen;
    bit m_tick;
    int m_phase;
    int m_ticks;

    tick_gen_1s_if #(.SEC_W(8)) bus ();
    tick_gen_1s_if #(.SEC_W(2)) busw ();

    tick_gen_1s #(.CLK_HZ(10), .TICK_HZ(1), .SEC_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    tick_gen_1s #(.CLK_HZ(10), .TICK_HZ(1), .SEC_W(2)) dutw (
        .clk(clk),
        .rst(rst),
        .bus(busw)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic p, input logic pa);
        bus.start  = s;  bus.stop  = p;  bus.pause  = pa;
        busw.start = s;  busw.stop = p;  busw.pause = pa;
    endtask

    task automatic model_reset();
        m_active = 0; m_frozen = 0; m_tick = 0; m_phase = 0; m_ticks = 0;
    endtask

    task automatic model_edge(input logic s, input logic p, input logic pa);
        m_tick = 0;
        if (p) begin
            m_active = 0; m_frozen = 0; m_phase = 0;
        end else if (s) begin
            m_active = 1; m_frozen = 0; m_phase = 0; m_ticks = 0;
        end else if (pa && m_active) begin
            m_frozen = !m_frozen;
        end else if (m_active && !m_frozen) begin
            m_phase = m_phase + 1;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_tick  = 1;
                m_ticks = m_ticks + 1;
            end
        end
    endtask

    // One clock edge: inputs change at negedge, outputs observed 1 ns after posedge.
    task automatic step(input logic s, input logic p, input logic pa);
        @(negedge clk);
        drive(s, p, pa);
        @(posedge clk);
        model_edge(s, p, pa);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.timeout1s, bus.running, bus.paused, bus.elapsed} !== 11'd0) begin
            bad++; $display("FAIL reset_hold: got %b want 0", {bus.timeout1s, bus.running, bus.paused, bus.elapsed});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0);
        for (int e = 1; e <= 10; e++) step(0, 0, 0);
        total++;
        if (bus.timeout1s !== 1'b1 || bus.elapsed !== 8'd1) begin
            bad++; $display("FAIL reset_pre_tick: got tick=%b el=%0d want tick=1 el=1", bus.timeout1s, bus.elapsed);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({bus.timeout1s, bus.running, bus.paused, bus.elapsed,
             busw.timeout1s, busw.running, busw.paused, busw.elapsed} !== 16'd0) begin
            bad++; $display("FAIL reset_async: got %b %b %b %0d want all 0",
                            bus.timeout1s, bus.running, bus.paused, bus.elapsed);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            step(0, 0, 0);
            total++;
            if ({bus.timeout1s, bus.running, bus.paused, bus.elapsed} !== 11'd0) begin
                bad++; $display("FAIL reset_idle e=%0d: got %b %b %b %0d want all 0",
                                e, bus.timeout1s, bus.running, bus.paused, bus.elapsed);
            end
        end
    endtask

    task automatic test_free_run();
        logic       xt;
        logic [7:0] xe;
        step(0, 1, 0);
        step(1, 0, 0);
        for (int e = 1; e <= 30; e++) begin
            step(0, 0, 0);
            xt = (e % 10 == 0);
            xe = 8'(e / 10);
            total++;
            if (bus.timeout1s !== xt || bus.running !== 1'b1 || bus.elapsed !== xe) begin
                bad++; $display("FAIL free_run e=%0d: got tick=%b run=%b el=%0d want tick=%b run=1 el=%0d",
                                e, bus.timeout1s, bus.running, bus.elapsed, xt, xe);
            end
        end
    endtask

    task automatic test_pause();
        logic       xt, xp;
        logic [7:0] xe;
        step(0, 1, 0);
        step(1, 0, 0);
        for (int e = 1; e <= 30; e++) begin
            step(0, 0, logic'(e == 4 || e == 11));
            xt = (e == 18 || e == 28);
            xp = (e >= 4 && e <= 10);
            xe = (e >= 28) ? 8'd2 : (e >= 18) ? 8'd1 : 8'd0;
            total++;
            if (bus.timeout1s !== xt || bus.paused !== xp || bus.running !== !xp || bus.elapsed !== xe) begin
                bad++; $display("FAIL pause e=%0d: got tick=%b pz=%b run=%b el=%0d want tick=%b pz=%b el=%0d",
                                e, bus.timeout1s, bus.paused, bus.running, bus.elapsed, xt, xp, xe);
            end
        end
    endtask

    task automatic test_pause_boundary();
        logic       xt, xp;
        logic [7:0] xe;
        step(0, 1, 0);
        step(1, 0, 0);
        for (int e = 1; e <= 15; e++) begin
            step(0, 0, logic'(e == 10 || e == 12));
            xt = (e == 13);
            xp = (e == 10 || e == 11);
            xe = (e >= 13) ? 8'd1 : 8'd0;
            total++;
            if (bus.timeout1s !== xt || bus.paused !== xp || bus.elapsed !== xe) begin
                bad++; $display("FAIL pause_edge e=%0d: got tick=%b pz=%b el=%0d want tick=%b pz=%b el=%0d",
                                e, bus.timeout1s, bus.paused, bus.elapsed, xt, xp, xe);
            end
        end
    endtask

    task automatic test_stop_restart();
        logic       xt, xr;
        logic [7:0] xe;
        step(0, 1, 0);
        step(1, 0, 0);
        for (int e = 1; e <= 32; e++) begin
            step(logic'(e == 20), logic'(e == 7), 0);
            xt = (e == 30);
            xr = (e < 7 || e >= 20);
            xe = (e >= 30) ? 8'd1 : 8'd0;
            total++;
            if (bus.timeout1s !== xt || bus.running !== xr || bus.elapsed !== xe) begin
                bad++; $display("FAIL stop_start e=%0d: got tick=%b run=%b el=%0d want tick=%b run=%b el=%0d",
                                e, bus.timeout1s, bus.running, bus.elapsed, xt, xr, xe);
            end
        end
        step(0, 1, 0);
        step(1, 0, 0);
        for (int e = 1; e <= 26; e++) begin
            step(logic'(e == 15), 0, 0);
            xt = (e == 10 || e == 25);
            xe = (e >= 25 || (e >= 10 && e < 15)) ? 8'd1 : 8'd0;
            total++;
            if (bus.timeout1s !== xt || bus.running !== 1'b1 || bus.elapsed !== xe) begin
                bad++; $display("FAIL restart e=%0d: got tick=%b run=%b el=%0d want tick=%b run=1 el=%0d",
                                e, bus.timeout1s, bus.running, bus.elapsed, xt, xe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rp;
        logic [1:0] want [5];
        logic       s_v [5];
        logic       p_v [5];
        logic       pa_v [5];
        step(0, 1, 0);
        // {running, paused} after: stop+start, start+pause, pause, start+pause, pause
        s_v  = '{1, 1, 0, 1, 0};
        p_v  = '{1, 0, 0, 0, 0};
        pa_v = '{0, 1, 1, 1, 1};
        want = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 5; i++) begin
            step(s_v[i], p_v[i], pa_v[i]);
            rp = {bus.running, bus.paused};
            total++;
            if (rp !== want[i]) begin
                bad++; $display("FAIL b2b i=%0d: got run/pz=%b want %b", i, rp, want[i]);
            end
        end
        step(0, 0, 1);
        for (int e = 1; e <= 10; e++) begin
            step(0, 0, 0);
            total++;
            if (bus.timeout1s !== logic'(e == 10)) begin
                bad++; $display("FAIL b2b_tick e=%0d: got %b want %b", e, bus.timeout1s, e == 10);
            end
        end
    endtask

    task automatic test_wrap();
        logic       xt;
        logic [1:0] xe;
        step(0, 1, 0);
        step(1, 0, 0);
        for (int e = 1; e <= 50; e++) begin
            step(0, 0, 0);
            xt = (e % 10 == 0);
            xe = 2'((e / 10) % 4);
            total++;
            if (busw.timeout1s !== xt || busw.elapsed !== xe) begin
                bad++; $display("FAIL wrap e=%0d: got tick=%b el=%0d want tick=%b el=%0d",
                                e, busw.timeout1s, busw.elapsed, xt, xe);
            end
        end
    endtask

    task automatic test_random();
        int         r;
        logic       s, p, pa;
        logic [7:0] xe;
        logic [1:0] xw;
        for (int n = 0; n < 3000; n++) begin
            r  = int'($urandom_range(0, 99));
            s  = (r < 3);
            p  = (r >= 3 && r < 5);
            pa = (r >= 5 && r < 10);
            step(s, p, pa);
            xe = 8'(m_ticks);
            xw = 2'(m_ticks);
            total++;
            if (bus.timeout1s !== m_tick || bus.running !== (m_active && !m_frozen) ||
                bus.paused !== (m_active && m_frozen) || bus.elapsed !== xe) begin
                bad++; $display("FAIL random n=%0d: got tick=%b run=%b pz=%b el=%0d want tick=%b run=%b pz=%b el=%0d",
                                n, bus.timeout1s, bus.running, bus.paused, bus.elapsed,
                                m_tick, m_active && !m_frozen, m_active && m_frozen, xe);
            end
            total++;
            if (busw.timeout1s !== m_tick || busw.elapsed !== xw) begin
                bad++; $display("FAIL random_w n=%0d: got tick=%b el=%0d want tick=%b el=%0d",
                                n, busw.timeout1s, busw.elapsed, m_tick, xw);
            end
        end
    endtask

    initial begin
        drive(0, 0, 0);
        model_reset();
        #3;
        test_reset();
        test_free_run();
        test_pause();
        test_pause_boundary();
        test_stop_restart();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
